// File: rtl/float_div_seq_if.sv
// Operand/result handshake bundle for float_div_seq: valid/ready on the operand side
// and on the result side, operands and result in packed {sign, exp, frac} format.
interface float_div_seq_if #(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned FRAC_W = 23
);
  localparam int unsigned W = 1 + EXP_W + FRAC_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [4:0]   flags;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/float_div_seq.sv
// Multi-cycle IEEE-754 divider (a / b, round-to-nearest-even) using restoring division,
// one quotient bit per cycle; subnormal operands and results flush to zero.
module float_div_seq #(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned FRAC_W = 23,
  parameter int unsigned BIAS   = 127
) (
  input  logic           clk,
  input  logic           rst_n,
  float_div_seq_if.slave bus
);
  localparam int unsigned W  = 1 + EXP_W + FRAC_W;
  localparam int unsigned MW = FRAC_W + 1;
  localparam int unsigned QW = FRAC_W + 3;
  localparam int unsigned EW = EXP_W + 2;
  localparam int unsigned CW = $clog2(QW);

  localparam logic signed [EW-1:0] EXP_MAX  = EW'((2 ** EXP_W) - 1);
  localparam logic signed [EW-1:0] EXP_ZERO = '0;
  localparam logic signed [EW-1:0] EXP_ONE  = EW'(1);
  localparam logic signed [EW-1:0] EXP_BIAS = EW'(BIAS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_DIV,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [W-1:0]           a_q, a_d;
  logic [W-1:0]           b_q, b_d;
  logic                   sign_q, sign_d;
  logic                   special_q, special_d;
  logic [W-1:0]           spec_res_q, spec_res_d;
  logic [4:0]             spec_flg_q, spec_flg_d;
  logic signed [EW-1:0]   exp_q, exp_d;
  logic [MW:0]            rem_q, rem_d;
  logic [QW-1:0]          quo_q, quo_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [W-1:0]           result_q, result_d;
  logic [4:0]             flags_q, flags_d;

  logic                   in_ready, out_valid;

  // Operand classification
  logic [EXP_W-1:0]  ea, eb;
  logic [FRAC_W-1:0] fa, fb;
  logic              sa, sb;
  logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [MW-1:0]     mb;

  assign sa     = a_q[W-1];
  assign sb     = b_q[W-1];
  assign ea     = a_q[W-2 -: EXP_W];
  assign eb     = b_q[W-2 -: EXP_W];
  assign fa     = a_q[FRAC_W-1:0];
  assign fb     = b_q[FRAC_W-1:0];
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == '1) && (fa == '0);
  assign b_inf  = (eb == '1) && (fb == '0);
  assign a_nan  = (ea == '1) && (fa != '0);
  assign b_nan  = (eb == '1) && (fb != '0);
  assign mb     = {1'b1, fb};

  // Restoring step: a set bit means the divisor fits; diff stays below mb so it fits in MW bits
  logic          fits;
  logic [MW-1:0] diff;

  assign fits = (rem_q >= {1'b0, mb});
  assign diff = fits ? (rem_q[MW-1:0] - mb) : rem_q[MW-1:0];

  // Rounding: hidden bit is always set after NORM, so the carry out of the fraction
  // is the carry out of the whole significand and leaves a zero fraction behind
  logic                 guard, rnd, sticky, round_up, carry, inexact;
  logic [FRAC_W:0]      frac_sum;
  logic signed [EW-1:0] exp_r;

  assign guard    = quo_q[1];
  assign rnd      = quo_q[0];
  assign sticky   = (rem_q != '0);
  assign round_up = guard & (rnd | sticky | quo_q[2]);
  assign frac_sum = {1'b0, quo_q[QW-2:2]} + {{FRAC_W{1'b0}}, round_up};
  assign carry    = frac_sum[FRAC_W];
  assign inexact  = guard | rnd | sticky;
  assign exp_r    = exp_q + $signed({{(EW-1){1'b0}}, carry});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Specials detour through ROUND so their result lands two edges after accept
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.in_valid) state_d = S_CHECK;
      S_CHECK: state_d = special_d ? S_ROUND : S_DIV;
      S_DIV:   if (cnt_q == '0) state_d = S_NORM;
      S_NORM:  state_d = S_ROUND;
      S_ROUND: state_d = S_DONE;
      S_DONE:  if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;

  always_comb begin
    a_d        = a_q;
    b_d        = b_q;
    sign_d     = sign_q;
    special_d  = special_q;
    spec_res_d = spec_res_q;
    spec_flg_d = spec_flg_q;
    exp_d      = exp_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    flags_d    = flags_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_d = bus.a;
          b_d = bus.b;
        end
      end
      S_CHECK: begin
        sign_d     = sa ^ sb;
        special_d  = 1'b1;
        spec_flg_d = '0;
        exp_d      = $signed({2'b00, ea}) - $signed({2'b00, eb}) + EXP_BIAS;
        rem_d      = {2'b01, fa};
        quo_d      = '0;
        cnt_d      = CW'(QW - 1);
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
          spec_res_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
          spec_flg_d = 5'b10000;
        end else if (a_inf) begin
          spec_res_d = {sa ^ sb, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end else if (b_zero) begin
          spec_res_d = {sa ^ sb, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
          spec_flg_d = 5'b01000;
        end else if (a_zero || b_inf) begin
          spec_res_d = {sa ^ sb, {(W-1){1'b0}}};
        end else begin
          special_d = 1'b0;
        end
      end
      S_DIV: begin
        rem_d = {diff, 1'b0};
        quo_d = {quo_q[QW-2:0], fits};
        cnt_d = cnt_q - CW'(1);
      end
      S_NORM: begin
        if (!quo_q[QW-1]) begin
          quo_d = {quo_q[QW-2:0], 1'b0};
          exp_d = exp_q - EXP_ONE;
        end
      end
      S_ROUND: begin
        if (special_q) begin
          result_d = spec_res_q;
          flags_d  = spec_flg_q;
        end else if (exp_r >= EXP_MAX) begin
          result_d = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
          flags_d  = 5'b00101;
        end else if (exp_r <= EXP_ZERO) begin
          result_d = {sign_q, {(W-1){1'b0}}};
          flags_d  = 5'b00011;
        end else begin
          result_d = {sign_q, exp_r[EXP_W-1:0], frac_sum[FRAC_W-1:0]};
          flags_d  = {4'b0000, inexact};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      sign_q     <= 1'b0;
      special_q  <= 1'b0;
      spec_res_q <= '0;
      spec_flg_q <= '0;
      exp_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      flags_q    <= '0;
    end else begin
      a_q        <= a_d;
      b_q        <= b_d;
      sign_q     <= sign_d;
      special_q  <= special_d;
      spec_res_q <= spec_res_d;
      spec_flg_q <= spec_flg_d;
      exp_q      <= exp_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      flags_q    <= flags_d;
    end
  end
endmodule

// File: tb/tb_float_div_seq.sv
// Self-checking bench for float_div_seq: directed cases, randomized operands against an
// exact-quotient reference model, backpressure and mid-operation reset.
module tb_float_div_seq;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  float_div_seq_if #(.EXP_W(8), .FRAC_W(23)) bus ();

  float_div_seq #(.EXP_W(8), .FRAC_W(23), .BIAS(127)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Exact quotient with integer division, then IEEE round-to-nearest-even on the true remainder
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [4:0] f, output int lat);
    int      ea, eb, e, sh;
    bit      s, az, bz, ai, bi, an, bn, inx;
    longint  ma, mb, num, q, rm, mant, tail, half;
    ea  = int'(a[30:23]);
    eb  = int'(b[30:23]);
    s   = a[31] ^ b[31];
    az  = (ea == 0);
    bz  = (eb == 0);
    ai  = (ea == 255) && (a[22:0] == 0);
    bi  = (eb == 255) && (b[22:0] == 0);
    an  = (ea == 255) && (a[22:0] != 0);
    bn  = (eb == 255) && (b[22:0] != 0);
    f   = 5'b00000;
    lat = 2;
    if (an || bn || (az && bz) || (ai && bi)) begin
      r = 32'h7FC00000;
      f = 5'b10000;
    end else if (ai) begin
      r = {s, 8'hFF, 23'h0};
    end else if (bz) begin
      r = {s, 8'hFF, 23'h0};
      f = 5'b01000;
    end else if (az || bi) begin
      r = {s, 31'h0};
    end else begin
      lat  = 29;
      ma   = longint'({1'b1, a[22:0]});
      mb   = longint'({1'b1, b[22:0]});
      num  = ma << 25;
      q    = num / mb;
      rm   = num % mb;
      e    = ea - eb + 127;
      sh   = (q >= (64'sd1 << 25)) ? 2 : 1;
      if (sh == 1) e = e - 1;
      mant = q >> sh;
      tail = q & ((64'sd1 << sh) - 1);
      half = 64'sd1 << (sh - 1);
      inx  = (tail != 0) || (rm != 0);
      if ((tail > half) || ((tail == half) && ((rm != 0) || mant[0]))) mant = mant + 1;
      if (mant == (64'sd1 << 24)) begin
        mant = mant >> 1;
        e    = e + 1;
      end
      if (e >= 255) begin
        r = {s, 8'hFF, 23'h0};
        f = 5'b00101;
      end else if (e <= 0) begin
        r = {s, 31'h0};
        f = 5'b00011;
      end else begin
        r = {s, e[7:0], mant[22:0]};
        f = {4'b0000, inx};
      end
    end
  endfunction

  // Drives one operation; latency counts rising edges after the accept edge until out_valid
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input bit take,
                       output logic [31:0] r, output logic [4:0] f, output int lat, output bit to);
    int n;
    to = 1'b0;
    @(negedge clk);
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) to = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!bus.out_valid && lat < 100);
    if (!bus.out_valid) to = 1'b1;
    r = bus.result;
    f = bus.flags;
    if (take) begin
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
    end
    checks++;
    if (bus.result !== 32'h0) begin
      errors++;
      $display("FAIL reset_result: got %h want 00000000", bus.result);
    end
    checks++;
    if (bus.flags !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 00000", bus.flags);
    end
  endtask

  task automatic test_directed();
    logic [31:0] va [7];
    logic [31:0] vb [7];
    logic [31:0] wr [7];
    logic [4:0]  wf [7];
    int          wl [7];
    logic [31:0] r;
    logic [4:0]  f;
    int          lat;
    bit          to;
    va = '{32'h40C00000, 32'h3F800000, 32'h3F800000, 32'h00000000, 32'hC0000000, 32'h7F000000, 32'h00800000};
    vb = '{32'h40000000, 32'h40400000, 32'h00000000, 32'h00000000, 32'h7F800000, 32'h3E800000, 32'h40000000};
    wr = '{32'h40400000, 32'h3EAAAAAB, 32'h7F800000, 32'h7FC00000, 32'h80000000, 32'h7F800000, 32'h00000000};
    wf = '{5'b00000, 5'b00001, 5'b01000, 5'b10000, 5'b00000, 5'b00101, 5'b00011};
    wl = '{29, 29, 2, 2, 2, 29, 29};
    for (int i = 0; i < 7; i++) begin
      do_op(va[i], vb[i], 1'b1, r, f, lat, to);
      checks++;
      if (to) begin
        errors++;
        $display("FAIL directed_timeout[%0d]: handshake did not complete", i);
      end
      checks++;
      if (r !== wr[i]) begin
        errors++;
        $display("FAIL directed_result[%0d]: %h/%h got %h want %h", i, va[i], vb[i], r, wr[i]);
      end
      checks++;
      if (f !== wf[i]) begin
        errors++;
        $display("FAIL directed_flags[%0d]: got %b want %b", i, f, wf[i]);
      end
      checks++;
      if (lat != wl[i]) begin
        errors++;
        $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, wl[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] specials [8];
    logic [31:0] a, b, r, er;
    logic [4:0]  f, ef;
    int          lat, el, ea, eb;
    bit          to;
    specials = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
                 32'h7FC00001, 32'h00012345, 32'h3F800000, 32'hBFC00000};
    for (int i = 0; i < 24; i++) begin
      ea = int'($urandom_range(1, 254));
      if ($urandom_range(0, 3) == 0) eb = int'($urandom_range(1, 254));
      else eb = ea + int'($urandom_range(0, 20)) - 10;
      if (eb < 1) eb = 1;
      if (eb > 254) eb = 254;
      a = {1'($urandom_range(0, 1)), 8'(ea), 23'($urandom)};
      b = {1'($urandom_range(0, 1)), 8'(eb), 23'($urandom)};
      if (i % 6 == 5) a = specials[$urandom_range(0, 7)];
      if (i % 6 == 4) b = specials[$urandom_range(0, 7)];
      ref_div(a, b, er, ef, el);
      do_op(a, b, 1'b1, r, f, lat, to);
      checks++;
      if (to || r !== er) begin
        errors++;
        $display("FAIL random_result[%0d]: %h/%h got %h want %h timeout=%0d", i, a, b, r, er, to);
      end
      checks++;
      if (f !== ef) begin
        errors++;
        $display("FAIL random_flags[%0d]: %h/%h got %b want %b", i, a, b, f, ef);
      end
      checks++;
      if (lat != el) begin
        errors++;
        $display("FAIL random_latency[%0d]: got %0d want %0d", i, lat, el);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] r;
    logic [4:0]  f;
    int          lat;
    bit          to;
    do_op(32'h40C00000, 32'h40000000, 1'b0, r, f, lat, to);
    checks++;
    if (to || r !== 32'h40400000) begin
      errors++;
      $display("FAIL bp_first_result: got %h want 40400000 timeout=%0d", r, to);
    end
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        bus.a        = 32'h3F800000;
        bus.b        = 32'h40400000;
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_hs[%0d]: out_valid=%b in_ready=%b want 1/0", i, bus.out_valid, bus.in_ready);
      end
      checks++;
      if (bus.result !== 32'h40400000 || bus.flags !== 5'b0) begin
        errors++;
        $display("FAIL bp_hold_data[%0d]: got %h/%b want 40400000/00000", i, bus.result, bus.flags);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready);
    end
    checks++;
    if (bus.result !== 32'h40400000) begin
      errors++;
      $display("FAIL bp_result_held: got %h want 40400000", bus.result);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_ignored_pulse: out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset_mid_div();
    logic [31:0] r;
    logic [4:0]  f;
    int          lat;
    bit          to, seen;
    @(negedge clk);
    bus.a        = 32'h3F800000;
    bus.b        = 32'h40400000;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.result !== 32'h0 || bus.flags !== 5'b0) begin
      errors++;
      $display("FAIL rst_mid_clear: out_valid=%b result=%h flags=%b want 0/00000000/00000",
               bus.out_valid, bus.result, bus.flags);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_release: in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid);
    end
    seen = 1'b0;
    repeat (35) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL rst_mid_no_output: got out_valid=1 want no output");
    end
    do_op(32'h40C00000, 32'h40000000, 1'b1, r, f, lat, to);
    checks++;
    if (to || r !== 32'h40400000 || f !== 5'b0) begin
      errors++;
      $display("FAIL rst_mid_next_op: got %h/%b want 40400000/00000 timeout=%0d", r, f, to);
    end
    checks++;
    if (lat != 29) begin
      errors++;
      $display("FAIL rst_mid_next_latency: got %0d want 29", lat);
    end
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid_div();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
